exec_writeback_stage: RTL and testbench
=======================================

Name: exec_writeback_stage

Overview:
- Execute/writeback boundary register placed directly after the ALU in the 16-bit pipeline.
- Consumes the ALU result bus (out, S/Z/C/V, HLT, flush) and owns the architectural flag register that feeds the ALU's S_in/Z_in/C_in/V_in.
- Converts flush into a one-cycle PC redirect plus squash of younger instructions.
- Latches HLT into a sticky halted state.

Parameters:
- DATA_W, 16, datapath width.
- REG_ADDR_W, 3, register-file address width.
- FLUSH_DEPTH, 2, number of younger valid instructions discarded after a taken flush (legal range 1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  freezes the stage
- ex_valid  in  1  ALU outputs hold a real instruction
- alu_out  in  DATA_W  ALU result or branch target
- alu_S, alu_Z, alu_C, alu_V  in  1 each  ALU flag results
- alu_HLT  in  1  halt request
- alu_flush  in  1  taken branch/jump
- ex_rd  in  REG_ADDR_W  destination register
- ex_reg_we  in  1  instruction writes the register file
- ex_flag_we  in  1  instruction updates flags
- flag_S, flag_Z, flag_C, flag_V  out  1 each  architectural flags; drive ALU S_in..V_in
- wb_valid  out  1  writeback data valid
- wb_data  out  DATA_W  writeback data
- wb_rd  out  REG_ADDR_W  writeback address
- wb_we  out  1  register-file write enable
- pc_redirect  out  1  one-cycle redirect pulse
- pc_target  out  DATA_W  redirect target
- squash  out  1  high while discarding younger instructions
- halted  out  1  sticky halt
- retire_cnt  out  16  retired-instruction count (optional feature)

Behaviour:
- Reset: every output is 0, state=RUN, squash counter=0. Reset mid-SQUASH or mid-HALT also returns to RUN.
- States:
  - RUN: normal acceptance.
  - SQUASH: discarding younger instructions.
  - HALT: terminal until rst.
- Accept condition: ex_valid & !stall & state==RUN. Latency is 1 cycle: fields appear on wb_* at the next edge.
- On accept:
  - wb_valid=1, wb_data=alu_out, wb_rd=ex_rd, wb_we=ex_reg_we.
  - If ex_flag_we, flag_* <= alu_*; otherwise flags hold. Flags are therefore visible to the next instruction in EX one cycle later.
- No accept and !stall: wb_valid=0, wb_we=0.
- stall=1:
  - All registers hold: wb_*, flags, state, squash counter.
  - Exception: pc_redirect still deasserts after its single cycle.
- Accept with alu_flush=1 and alu_HLT=0:
  - The instruction itself still writes back per ex_reg_we (link value).
  - Next cycle: pc_redirect=1, pc_target=alu_out.
  - State goes to SQUASH with counter=FLUSH_DEPTH.
- SQUASH:
  - squash=1.
  - Each cycle with ex_valid & !stall discards that instruction (no wb, no flag update, its flush/HLT ignored) and decrements the counter.
  - Counter reaching 0 returns to RUN; squash drops the same edge.
  - Cycles with ex_valid=0 do not decrement.
- Accept with alu_HLT=1:
  - No writeback, no flag update.
  - halted=1 from next cycle; state=HALT.
  - alu_flush is ignored (HLT wins).
- HALT: all inputs ignored, wb_valid=0, halted stays 1 until rst.
- ex_valid=0: alu_flush and alu_HLT are ignored.

Optional Feature:
- Macro: EXEC_WB_RETIRE_CNT_EN.
- Defined: retire_cnt increments by 1 on every accepted non-squashed instruction, including branches, excluding HLT. It wraps 0xFFFF->0x0000, holds under stall, and resets to 0.
- Undefined: retire_cnt is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset then ex_valid, alu_out=0x1234, ex_rd=3, ex_reg_we=1, ex_flag_we=1, alu_Z=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=3, wb_we=1, flag_Z=1, other flags 0.
- ex_flag_we=0 with alu_S=1 after the previous case -> flag_S stays 0, flag_Z stays 1.
- Flush with alu_out=0x0040, then 3 consecutive valid instructions (FLUSH_DEPTH=2) -> pc_redirect high exactly 1 cycle with pc_target=0x0040, first 2 instructions discarded with squash=1, third written back.
- Flush followed by an ex_valid=0 bubble then 2 valid instructions -> bubble does not decrement; both instructions squashed.
- stall=1 for 3 cycles mid-SQUASH with ex_valid=1 -> counter, flags and wb_* unchanged; resumes on stall=0.
- alu_HLT=1 and alu_flush=1 together -> halted=1, pc_redirect=0, no wb. Later instructions ignored; rst clears halted. With EXEC_WB_RETIRE_CNT_EN, retire_cnt counts only the non-squashed, non-HLT accepted instructions.

Source files
------------

// File: rtl/exec_writeback_stage.sv
// Execute/writeback boundary register placed after the ALU.
// Registers the ALU result for writeback and holds the architectural flags.
// A taken flush produces a one-cycle PC redirect and then discards
// FLUSH_DEPTH younger instructions. A halt request moves the stage into a
// sticky halted state.
// Optional feature: define EXEC_WB_RETIRE_CNT_EN to count retired instructions.
module exec_writeback_stage #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned REG_ADDR_W  = 3,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic                  alu_S,
  input  logic                  alu_Z,
  input  logic                  alu_C,
  input  logic                  alu_V,
  input  logic                  alu_HLT,
  input  logic                  alu_flush,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_we,
  input  logic                  ex_flag_we,
  output logic                  flag_S,
  output logic                  flag_Z,
  output logic                  flag_C,
  output logic                  flag_V,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_we,
  output logic                  pc_redirect,
  output logic [DATA_W-1:0]     pc_target,
  output logic                  squash,
  output logic                  halted,
  output logic [15:0]           retire_cnt
);

  typedef enum logic [1:0] {StRun, StSquash, StHalt} state_e;

  localparam logic [2:0] SquashInit = 3'(FLUSH_DEPTH);

  state_e                state_q, state_d;
  logic [2:0]            sq_cnt_q, sq_cnt_d;
  logic                  flag_s_q, flag_s_d;
  logic                  flag_z_q, flag_z_d;
  logic                  flag_c_q, flag_c_d;
  logic                  flag_v_q, flag_v_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_we_q, wb_we_d;
  logic                  redirect_q, redirect_d;
  logic [DATA_W-1:0]     target_q, target_d;

  // Next-state: acceptance, squash countdown, halt entry; stall freezes all but redirect.
  always_comb begin
    state_d    = state_q;
    sq_cnt_d   = sq_cnt_q;
    flag_s_d   = flag_s_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    flag_v_d   = flag_v_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    redirect_d = 1'b0;
    target_d   = target_q;
    if (!stall) begin
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
      unique case (state_q)
        StRun: begin
          if (ex_valid) begin
            if (alu_HLT) begin
              // Halt wins over flush and suppresses writeback.
              state_d = StHalt;
            end else begin
              wb_valid_d = 1'b1;
              wb_data_d  = alu_out;
              wb_rd_d    = ex_rd;
              wb_we_d    = ex_reg_we;
              if (ex_flag_we) begin
                flag_s_d = alu_S;
                flag_z_d = alu_Z;
                flag_c_d = alu_C;
                flag_v_d = alu_V;
              end
              if (alu_flush) begin
                redirect_d = 1'b1;
                target_d   = alu_out;
                state_d    = StSquash;
                sq_cnt_d   = SquashInit;
              end
            end
          end
        end
        StSquash: begin
          // Only real instructions consume a squash slot; bubbles do not.
          if (ex_valid) begin
            sq_cnt_d = sq_cnt_q - 3'd1;
            if (sq_cnt_q == 3'd1) begin
              state_d = StRun;
            end
          end
        end
        StHalt: begin
          state_d = StHalt;
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      sq_cnt_q   <= '0;
      flag_s_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_v_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      sq_cnt_q   <= sq_cnt_d;
      flag_s_q   <= flag_s_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
      flag_v_q   <= flag_v_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
    end
  end

`ifdef EXEC_WB_RETIRE_CNT_EN
  logic [15:0] retire_q;
  logic        retire_inc;

  // Branches retire too; halts and squashed instructions never do.
  assign retire_inc = ex_valid & ~stall & (state_q == StRun) & ~alu_HLT;

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
    end else if (retire_inc) begin
      retire_q <= retire_q + 16'd1;
    end
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = '0;
`endif

  assign flag_S      = flag_s_q;
  assign flag_Z      = flag_z_q;
  assign flag_C      = flag_c_q;
  assign flag_V      = flag_v_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign wb_we       = wb_we_q;
  assign pc_redirect = redirect_q;
  assign pc_target   = target_q;
  assign squash      = (state_q == StSquash);
  assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_exec_writeback_stage.sv
// Bench for exec_writeback_stage: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the stage.
module tb_exec_writeback_stage;

  localparam int FlushDepth = 2;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic [15:0] alu_out;
  logic        alu_S, alu_Z, alu_C, alu_V;
  logic        alu_HLT;
  logic        alu_flush;
  logic [2:0]  ex_rd;
  logic        ex_reg_we;
  logic        ex_flag_we;
  logic        flag_S, flag_Z, flag_C, flag_V;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_we;
  logic        pc_redirect;
  logic [15:0] pc_target;
  logic        squash;
  logic        halted;
  logic [15:0] retire_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: what an observer must see after each clock edge.
  bit          m_halted;
  int          m_squash_left;
  bit [3:0]    m_flags;  // {S,Z,C,V}
  bit          m_wb_valid;
  bit [15:0]   m_wb_data;
  bit [2:0]    m_wb_rd;
  bit          m_wb_we;
  bit          m_redirect;
  bit [15:0]   m_target;
  bit [15:0]   m_retired;

  exec_writeback_stage #(
    .DATA_W     (16),
    .REG_ADDR_W (3),
    .FLUSH_DEPTH(FlushDepth)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .alu_out    (alu_out),
    .alu_S      (alu_S),
    .alu_Z      (alu_Z),
    .alu_C      (alu_C),
    .alu_V      (alu_V),
    .alu_HLT    (alu_HLT),
    .alu_flush  (alu_flush),
    .ex_rd      (ex_rd),
    .ex_reg_we  (ex_reg_we),
    .ex_flag_we (ex_flag_we),
    .flag_S     (flag_S),
    .flag_Z     (flag_Z),
    .flag_C     (flag_C),
    .flag_V     (flag_V),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_we      (wb_we),
    .pc_redirect(pc_redirect),
    .pc_target  (pc_target),
    .squash     (squash),
    .halted     (halted),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_retire(input bit [15:0] n);
`ifdef EXEC_WB_RETIRE_CNT_EN
    return n;
`else
    return (n & 16'h0000);
`endif
  endfunction

  // Apply the stage's rules to the inputs present at this edge.
  task automatic model_update();
    if (rst) begin
      m_halted = 0; m_squash_left = 0; m_flags = '0;
      m_wb_valid = 0; m_wb_data = '0; m_wb_rd = '0; m_wb_we = 0;
      m_redirect = 0; m_target = '0; m_retired = '0;
      return;
    end
    m_redirect = 0;
    if (stall) return;
    m_wb_valid = 0;
    m_wb_we    = 0;
    if (m_halted || !ex_valid) return;
    if (m_squash_left > 0) begin
      m_squash_left--;
      return;
    end
    if (alu_HLT) begin
      m_halted = 1;
      return;
    end
    m_wb_valid = 1;
    m_wb_data  = alu_out;
    m_wb_rd    = ex_rd;
    m_wb_we    = ex_reg_we;
    m_retired  = m_retired + 16'd1;
    if (ex_flag_we) m_flags = {alu_S, alu_Z, alu_C, alu_V};
    if (alu_flush) begin
      m_redirect    = 1;
      m_target      = alu_out;
      m_squash_left = FlushDepth;
    end
  endtask

  task automatic compare_all();
    chk("wb_valid", 32'(wb_valid), 32'(m_wb_valid));
    chk("wb_we", 32'(wb_we), 32'(m_wb_we));
    if (m_wb_valid) begin
      chk("wb_data", 32'(wb_data), 32'(m_wb_data));
      chk("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
    end
    chk("flags", 32'({flag_S, flag_Z, flag_C, flag_V}), 32'(m_flags));
    chk("pc_redirect", 32'(pc_redirect), 32'(m_redirect));
    if (m_redirect) chk("pc_target", 32'(pc_target), 32'(m_target));
    chk("squash", 32'(squash), 32'(m_squash_left > 0));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("retire_cnt", 32'(retire_cnt), 32'(exp_retire(m_retired)));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    rst = 0; stall = 0; ex_valid = 0; alu_out = '0;
    alu_S = 0; alu_Z = 0; alu_C = 0; alu_V = 0;
    alu_HLT = 0; alu_flush = 0; ex_rd = '0; ex_reg_we = 0; ex_flag_we = 0;
  endtask

  task automatic plain(input logic [15:0] val);
    set_idle();
    ex_valid = 1; alu_out = val; ex_rd = 3'd5; ex_reg_we = 1;
  endtask

  initial begin
    set_idle();
    rst = 1;
    step();
    step();
    set_idle();
    chk("reset wb_valid", 32'(wb_valid), 32'd0);
    chk("reset flags", 32'({flag_S, flag_Z, flag_C, flag_V}), 32'd0);
    chk("reset halted", 32'(halted), 32'd0);

    // Basic writeback with flag update.
    ex_valid = 1; alu_out = 16'h1234; ex_rd = 3'd3; ex_reg_we = 1; ex_flag_we = 1; alu_Z = 1;
    step();
    chk("t1 wb_data", 32'(wb_data), 32'h1234);
    chk("t1 wb_rd", 32'(wb_rd), 32'd3);
    chk("t1 flags", 32'({flag_S, flag_Z, flag_C, flag_V}), 32'b0100);

    // No flag update when ex_flag_we=0.
    ex_flag_we = 0; alu_S = 1; alu_Z = 0;
    step();
    chk("t2 flag_S", 32'(flag_S), 32'd0);
    chk("t2 flag_Z", 32'(flag_Z), 32'd1);

    // Flush, then three valid instructions: two squashed, third retires.
    set_idle();
    ex_valid = 1; alu_out = 16'h0040; alu_flush = 1; ex_rd = 3'd7; ex_reg_we = 1;
    step();
    chk("t3 link wb_valid", 32'(wb_valid), 32'd1);
    chk("t3 redirect", 32'(pc_redirect), 32'd1);
    chk("t3 target", 32'(pc_target), 32'h0040);
    chk("t3 squash", 32'(squash), 32'd1);
    plain(16'h0001);
    step();
    chk("t3 redirect drop", 32'(pc_redirect), 32'd0);
    chk("t3 sq1 wb_valid", 32'(wb_valid), 32'd0);
    plain(16'h0002);
    step();
    chk("t3 squash end", 32'(squash), 32'd0);
    plain(16'h0003);
    step();
    chk("t3 third wb_data", 32'(wb_data), 32'h0003);
    chk("t3 retire_cnt", 32'(retire_cnt), 32'(exp_retire(16'd4)));

    // Flush, bubble, then two valid: bubble does not consume a slot.
    set_idle();
    ex_valid = 1; alu_out = 16'h0080; alu_flush = 1;
    step();
    set_idle();
    step();
    chk("t4 bubble squash", 32'(squash), 32'd1);
    plain(16'h0011);
    step();
    plain(16'h0012);
    step();
    chk("t4 squash end", 32'(squash), 32'd0);
    chk("t4 wb_valid", 32'(wb_valid), 32'd0);

    // Stall mid-squash freezes everything except the redirect pulse.
    set_idle();
    ex_valid = 1; alu_out = 16'h0100; alu_flush = 1; ex_reg_we = 1; ex_rd = 3'd2;
    step();
    plain(16'h0021);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5 stall squash", 32'(squash), 32'd1);
      chk("t5 stall wb held", 32'(wb_valid), 32'd1);
    end
    stall = 0;
    step();
    chk("t5 resume squash", 32'(squash), 32'd1);
    step();
    chk("t5 resume done", 32'(squash), 32'd0);

    // Halt with flush: halt wins, then everything ignored until reset.
    set_idle();
    ex_valid = 1; alu_HLT = 1; alu_flush = 1; alu_out = 16'h0200; ex_reg_we = 1;
    step();
    chk("t6 halted", 32'(halted), 32'd1);
    chk("t6 no redirect", 32'(pc_redirect), 32'd0);
    chk("t6 no wb", 32'(wb_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      plain(16'h0300 + 16'(i));
      step();
    end
    chk("t6 still halted", 32'(halted), 32'd1);
    set_idle();
    rst = 1;
    step();
    chk("t6 rst clears", 32'(halted), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      set_idle();
      rst        = m_halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
      stall      = ($urandom_range(0, 6) == 0);
      ex_valid   = ($urandom_range(0, 3) != 0);
      alu_out    = 16'($urandom);
      alu_S      = 1'($urandom);
      alu_Z      = 1'($urandom);
      alu_C      = 1'($urandom);
      alu_V      = 1'($urandom);
      alu_HLT    = ($urandom_range(0, 59) == 0);
      alu_flush  = ($urandom_range(0, 7) == 0);
      ex_rd      = 3'($urandom);
      ex_reg_we  = 1'($urandom);
      ex_flag_we = 1'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
